// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 1- or 2-word instructions from a 1-cycle-latency ROM and hands them to decode
module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int LEN_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [DATA_W-1:0] instr_op,
  output logic [DATA_W-1:0] instr_opd,
  output logic              instr_two
);
  typedef enum logic [2:0] {OP_A, OP_D, OPD_A, OPD_D, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, rom_addr_n, instr_pc_n;
  logic [DATA_W-1:0] instr_op_n, instr_opd_n;
  logic              instr_valid_n, instr_two_n;
  // next-state and next-register values; a jump overrides whatever the fetch was doing
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    rom_addr_n    = rom_addr;
    instr_valid_n = instr_valid;
    instr_pc_n    = instr_pc;
    instr_op_n    = instr_op;
    instr_opd_n   = instr_opd;
    instr_two_n   = instr_two;
    if (jmp_valid) begin
      pc_n          = jmp_addr;
      rom_addr_n    = jmp_addr;
      instr_valid_n = 1'b0;
      state_n       = OP_A;
    end else begin
      case (state)
        OP_A: state_n = OP_D;
        OP_D: begin
          instr_op_n = rom_data;
          instr_pc_n = pc;
          if (rom_data[LEN_BIT]) begin
            rom_addr_n = pc + ADDR_W'(1);
            state_n    = OPD_A;
          end else begin
            instr_opd_n   = '0;
            instr_two_n   = 1'b0;
            pc_n          = pc + ADDR_W'(1);
            instr_valid_n = 1'b1;
            state_n       = HOLD;
          end
        end
        OPD_A: state_n = OPD_D;
        OPD_D: begin
          instr_opd_n   = rom_data;
          instr_two_n   = 1'b1;
          pc_n          = pc + ADDR_W'(2);
          instr_valid_n = 1'b1;
          state_n       = HOLD;
        end
        HOLD: begin
          if (instr_valid && instr_ready) begin
            instr_valid_n = 1'b0;
            rom_addr_n    = pc;
            state_n       = OP_A;
          end
        end
        default: state_n = OP_A;
      endcase
    end
  end
  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= OP_A;
      pc          <= RESET_PC;
      rom_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      instr_op    <= '0;
      instr_opd   <= '0;
      instr_two   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      rom_addr    <= rom_addr_n;
      instr_valid <= instr_valid_n;
      instr_pc    <= instr_pc_n;
      instr_op    <= instr_op_n;
      instr_opd   <= instr_opd_n;
      instr_two   <= instr_two_n;
    end
  end
endmodule
